// File: rtl/rfaludm_mc.sv
// Multicycle register-file / ALU / data-memory slice: IDLE -> RD -> EX -> [MEM] -> WB.
// Optional sticky signed-overflow detection with write suppression under RFALUDM_OVF_EN.
module rfaludm_mc #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int DM_AW  = 6
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [RA_W-1:0]   Read1,
  input  logic [RA_W-1:0]   Read2,
  input  logic [RA_W-1:0]   ins_15_11,
  input  logic [15:0]       SEin,
  input  logic              RegDst,
  input  logic              RegWrite,
  input  logic              ALUSrc,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        ALUOp,
  output logic              Busy,
  output logic              Done,
  output logic              Zero,
  output logic [DATA_W-1:0] Result
`ifdef RFALUDM_OVF_EN
  ,
  output logic              Ovf
`endif
);

  localparam int NREG = 1 << RA_W;
  localparam int DM_D = 1 << DM_AW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    logic signed [DATA_W-1:0] r;
    r = {DATA_W{v[15]}};
    r[15:0] = v;
    return r;
  endfunction

`ifdef RFALUDM_OVF_EN
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] y);
    return (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] y);
    return (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
  endfunction
`endif

  logic [2:0] state;

  logic [DATA_W-1:0] rf   [NREG];
  logic [DATA_W-1:0] dmem [DM_D];

  // Launch: capture all decoded fields so the inputs are free to change afterwards
  logic [RA_W-1:0] rs_p0, rt_p0, rd_p0;
  logic [15:0]     imm_p0;
  logic            regdst_p0, regwrite_p0, alusrc_p0, memtoreg_p0, memwrite_p0, memread_p0;
  logic [1:0]      aluop_p0;

  always_ff @(posedge Clock) begin
    if (state == S_IDLE && Start) begin
      rs_p0       <= Read1;
      rt_p0       <= Read2;
      rd_p0       <= ins_15_11;
      imm_p0      <= SEin;
      regdst_p0   <= RegDst;
      regwrite_p0 <= RegWrite;
      alusrc_p0   <= ALUSrc;
      memtoreg_p0 <= MemtoReg;
      memwrite_p0 <= MemWrite;
      memread_p0  <= MemRead;
      aluop_p0    <= ALUOp;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (Start) state <= S_RD;
        S_RD:    state <= S_EX;
        S_EX:    state <= (memread_p0 || memwrite_p0) ? S_MEM : S_WB;
        S_MEM:   state <= S_WB;
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (state != S_IDLE);
  assign Done = (state == S_WB);

  // RD: operand fetch
  logic signed [DATA_W-1:0] data1_p1, data2_p1;

  always_ff @(posedge Clock) begin
    if (state == S_RD) begin
      data1_p1 <= (rs_p0 == '0) ? '0 : rf[rs_p0];
      data2_p1 <= (rt_p0 == '0) ? '0 : rf[rt_p0];
    end
  end

  // EX: ALU
  logic signed [DATA_W-1:0] opa, opb, sum, diff, alu_y;
  logic [5:0]               funct;

  assign funct = imm_p0[5:0];
  assign opa   = data1_p1;
  assign opb   = alusrc_p0 ? sext16(imm_p0) : data2_p1;
  assign sum   = opa + opb;
  assign diff  = opa - opb;

  always_comb begin
    alu_y = sum;
    case (aluop_p0)
      2'b01: alu_y = diff;
      2'b11: alu_y = opa | opb;
      2'b10: begin
        case (funct)
          6'h22:   alu_y = diff;
          6'h24:   alu_y = opa & opb;
          6'h25:   alu_y = opa | opb;
          6'h27:   alu_y = ~(opa | opb);
          6'h2A:   alu_y = (opa < opb) ? DATA_W'(1) : '0;
          default: alu_y = sum;
        endcase
      end
      default: alu_y = sum;
    endcase
  end

  logic ovf_blk;

`ifdef RFALUDM_OVF_EN
  logic is_sub, is_logic, ovf_ex, ovf_p2;

  always_comb begin
    is_sub   = (aluop_p0 == 2'b01) || (aluop_p0 == 2'b10 && funct == 6'h22);
    is_logic = (aluop_p0 == 2'b11) ||
               (aluop_p0 == 2'b10 && (funct == 6'h24 || funct == 6'h25 ||
                                      funct == 6'h27 || funct == 6'h2A));
    ovf_ex   = 1'b0;
    if (!is_logic) ovf_ex = is_sub ? sub_ovf(opa, opb, diff) : add_ovf(opa, opb, sum);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Ovf    <= 1'b0;
      ovf_p2 <= 1'b0;
    end else if (state == S_EX) begin
      ovf_p2 <= ovf_ex;
      if (ovf_ex) Ovf <= 1'b1;
    end
  end

  assign ovf_blk = ovf_p2;
`else
  assign ovf_blk = 1'b0;
`endif

  // EX -> MEM: memory word index and store data
  logic [DM_AW-1:0] addr_p2;

  always_ff @(posedge Clock) begin
    if (state == S_EX) addr_p2 <= alu_y[DM_AW+1:2];
  end

  logic [DATA_W-1:0] result_r;
  logic              zero_r;

  // Result carries the write-back value: ALU result from EX, replaced by memory data in MEM
  always_ff @(posedge Clock) begin
    if (Reset) begin
      result_r <= '0;
      zero_r   <= 1'b0;
    end else if (state == S_EX) begin
      result_r <= memtoreg_p0 ? '0 : alu_y;
      zero_r   <= (alu_y == '0);
    end else if (state == S_MEM && memtoreg_p0) begin
      result_r <= memread_p0 ? dmem[addr_p2] : '0;
    end
  end

  assign Result = result_r;
  assign Zero   = zero_r;

  // MEM: store is abandoned if reset arrives during the access
  always_ff @(posedge Clock) begin
    if (state == S_MEM && memwrite_p0 && !Reset) dmem[addr_p2] <= data2_p1;
  end

  // WB: register-file write
  logic [RA_W-1:0] dst_p3;
  logic            rf_we;

  assign dst_p3 = regdst_p0 ? rd_p0 : rt_p0;
  assign rf_we  = (state == S_WB) && regwrite_p0 && !ovf_blk && (dst_p3 != '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[dst_p3] <= result_r;
    end
  end

endmodule
